// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N_CH valid/ready producers in, one
// registered valid/ready beat with its channel index out.
interface rr_arb_mux_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
);
  localparam int SEL_W = $clog2(N_CH);

  logic                     mode;
  logic [N_CH*DATA_W-1:0]   in_data;
  logic [N_CH-1:0]          in_valid;
  logic [N_CH-1:0]          in_ready;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_valid;
  logic                     out_ready;

  // Environment side: drives producers and the downstream ready.
  modport master (
    output mode, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  // Arbiter side.
  modport slave (
    input  mode, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N_CH-to-1 valid/ready arbiter mux with a single-entry registered output
// stage. Round-robin (mode=0) or fixed priority, ch0 highest (mode=1).
module rr_arb_mux #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_arb_mux_if.slave   bus
);
  localparam int SEL_W = $clog2(N_CH);
  // One extra bit so ptr + offset can exceed N_CH-1 before wrapping.
  localparam int IW    = SEL_W + 1;

  logic [SEL_W-1:0]  ptr_q;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  sel_q;
  logic              valid_q;

  logic              load_en;
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt_idx;
  logic [IW-1:0]     start;
  logic [IW-1:0]     idx;
  logic              xfer;
  logic [SEL_W-1:0]  ptr_nxt;

  // Output stage can take a beat when empty or being drained this cycle.
  assign load_en = !valid_q || bus.out_ready;

  // Grant search: ascending from ptr (round-robin) or from 0 (fixed), wrapping at N_CH.
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    start   = bus.mode ? '0 : {1'b0, ptr_q};
    idx     = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = start + IW'(k);
      if (idx >= IW'(N_CH)) idx = idx - IW'(N_CH);
      if (!gnt_vld && bus.in_valid[idx[SEL_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[SEL_W-1:0];
      end
    end
  end

  // Ready is driven only toward the winner and never while in reset; no in_data path.
  always_comb begin
    bus.in_ready = '0;
    if (!rst && gnt_vld && load_en) bus.in_ready[gnt_idx] = 1'b1;
  end

  // The winner's valid is implied by the grant, so grant && load_en is the handshake.
  assign xfer    = !rst && gnt_vld && load_en;
  assign ptr_nxt = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;

  // Output stage and round-robin pointer, synchronous reset.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else if (xfer) begin
      valid_q <= 1'b1;
      data_q  <= bus.in_data[gnt_idx*DATA_W +: DATA_W];
      sel_q   <= gnt_idx;
      if (!bus.mode) ptr_q <= ptr_nxt;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench: a 4x8 and a 3x16 instance run side by side, each
// compared every cycle against a behavioural arbiter model.
module tb_rr_arb_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  bit   rand_b   = 1'b0;

  int   m_ptr [2];
  bit   m_v   [2];
  int   m_d   [2];
  int   m_s   [2];
  int   n_ch  [2] = '{4, 3};

  always #5 clk = ~clk;

  rr_arb_mux_if #(.N_CH(4), .DATA_W(8))  bus_a ();
  rr_arb_mux_if #(.N_CH(3), .DATA_W(16)) bus_b ();

  rr_arb_mux #(.N_CH(4), .DATA_W(8))  dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  rr_arb_mux #(.N_CH(3), .DATA_W(16)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // First valid channel scanning upward from the start point, wrapping at n.
  function automatic int exp_grant(input int inst, input int valid, input bit mode);
    int start = mode ? 0 : m_ptr[inst];
    for (int k = 0; k < n_ch[inst]; k++) begin
      int c = (start + k) % n_ch[inst];
      if ((valid >> c) & 1) return c;
    end
    return -1;
  endfunction

  function automatic int chan_data(input int inst, input int g);
    if (inst == 0) return int'((bus_a.in_data >> (8 * g)) & 32'hFF);
    return int'((bus_b.in_data >> (16 * g)) & 48'hFFFF);
  endfunction

  task automatic randomize_b();
    bus_b.mode      = 1'($urandom_range(0, 3) == 0);
    bus_b.in_valid  = 3'($urandom);
    bus_b.out_ready = 1'($urandom_range(0, 3) != 0);
    bus_b.in_data   = {16'($urandom), 32'($urandom)};
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic step();
    int g [2];
    int rdy [2];
    int cd [2];
    bit md [2];
    bit ordy [2];
    if (rand_b) randomize_b();
    #1;
    md[0] = bus_a.mode;   ordy[0] = bus_a.out_ready;
    md[1] = bus_b.mode;   ordy[1] = bus_b.out_ready;
    g[0]  = exp_grant(0, int'(bus_a.in_valid), md[0]);
    g[1]  = exp_grant(1, int'(bus_b.in_valid), md[1]);
    for (int i = 0; i < 2; i++) begin
      rdy[i] = (!rst && g[i] >= 0 && (!m_v[i] || ordy[i])) ? (1 << g[i]) : 0;
      cd[i]  = (g[i] >= 0) ? chan_data(i, g[i]) : 0;
    end
    check("a_in_ready", int'(bus_a.in_ready), rdy[0]);
    check("b_in_ready", int'(bus_b.in_ready), rdy[1]);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_v[i] = 1'b0; m_d[i] = 0; m_s[i] = 0; m_ptr[i] = 0;
      end else if (rdy[i] != 0) begin
        m_v[i] = 1'b1; m_d[i] = cd[i]; m_s[i] = g[i];
        if (!md[i]) m_ptr[i] = (g[i] + 1) % n_ch[i];
      end else if (ordy[i]) begin
        m_v[i] = 1'b0;
      end
    end
    #1;
    check("a_out_valid", int'(bus_a.out_valid), int'(m_v[0]));
    check("a_out_sel",   int'(bus_a.out_sel),   m_s[0]);
    check("a_out_data",  int'(bus_a.out_data),  m_d[0]);
    check("b_out_valid", int'(bus_b.out_valid), int'(m_v[1]));
    check("b_out_sel",   int'(bus_b.out_sel),   m_s[1]);
    check("b_out_data",  int'(bus_b.out_data),  m_d[1]);
  endtask

  initial begin
    int seq_a [6] = '{0, 1, 2, 3, 0, 1};
    int seq_b [6] = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_v[i] = 1'b0; m_d[i] = 0; m_s[i] = 0;
    end

    // Reset with every channel requesting.
    rst = 1'b1;
    bus_a.mode = 1'b0; bus_a.in_valid = 4'b1111; bus_a.out_ready = 1'b1;
    bus_b.mode = 1'b0; bus_b.in_valid = 3'b111;  bus_b.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) bus_a.in_data[c*8 +: 8] = 8'hA0 + 8'(c);
    for (int c = 0; c < 3; c++) bus_b.in_data[c*16 +: 16] = 16'hB000 + 16'(c);
    step();
    step();
    check("reset_out_valid", int'(bus_a.out_valid), 0);
    rst = 1'b0;

    // Fairness on both widths: first cycle after release grants ch0.
    #1;
    check("release_ready", int'(bus_a.in_ready), 4'b0001);
    for (int s = 0; s < 6; s++) begin
      step();
      check("rr_seq_a", int'(bus_a.out_sel), seq_a[s]);
      check("rr_data_a", int'(bus_a.out_data), 8'hA0 + seq_a[s]);
      check("rr_seq_b", int'(bus_b.out_sel), seq_b[s]);
    end
    rand_b = 1'b1;

    // Fixed priority: ch1 starves ch3 until it drops valid.
    bus_a.mode = 1'b1; bus_a.in_valid = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      step();
      check("fixed_sel1", int'(bus_a.out_sel), 1);
    end
    bus_a.in_valid = 4'b1000;
    step();
    check("fixed_sel3", int'(bus_a.out_sel), 3);

    // Backpressure after a ch2 beat of 8'h5C.
    bus_a.mode = 1'b0; bus_a.in_valid = 4'b0100; bus_a.in_data[16 +: 8] = 8'h5C;
    step();
    bus_a.out_ready = 1'b0; bus_a.in_valid = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      step();
      check("stall_data", int'(bus_a.out_data), 8'h5C);
      check("stall_sel", int'(bus_a.out_sel), 2);
    end
    bus_a.out_ready = 1'b1;
    step();
    check("unstall_valid", int'(bus_a.out_valid), 1);
    check("unstall_sel", int'(bus_a.out_sel), 3);

    // Sparse wrap: ptr=3 after a ch2 beat, ch0 alone wins, then drain.
    bus_a.in_valid = 4'b0100;
    step();
    bus_a.in_valid = 4'b0001;
    step();
    check("wrap_sel0", int'(bus_a.out_sel), 0);
    bus_a.in_valid = 4'b0000;
    step();
    check("drain_valid", int'(bus_a.out_valid), 0);
    bus_a.in_valid = 4'b1111;
    step();
    check("wrap_ptr1", int'(bus_a.out_sel), 1);

    // Mid-operation reset drops a stalled beat and clears ptr.
    bus_a.in_valid = 4'b0100; bus_a.out_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    check("midrst_valid", int'(bus_a.out_valid), 0);
    rst = 1'b0; bus_a.in_valid = 4'b1111; bus_a.out_ready = 1'b1;
    step();
    check("midrst_ptr0", int'(bus_a.out_sel), 0);

    // Randomized traffic on both instances with occasional reset.
    for (int s = 0; s < 400; s++) begin
      bus_a.mode      = 1'($urandom_range(0, 3) == 0);
      bus_a.in_valid  = 4'($urandom);
      bus_a.out_ready = 1'($urandom_range(0, 3) != 0);
      bus_a.in_data   = $urandom;
      rst             = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
